// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer with selectable bit order and a valid/ready holding register.
// Define SIPO_PARITY_EN to append a trailing even-parity bit to each frame and flag errors.
module sipo_deserializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         serial_in,
  input  logic                         serial_valid,
  input  logic                         clear,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         overrun,
  output logic                         out_parity_err,
  output logic [$clog2(WIDTH+2)-1:0]   bit_count
);

  localparam int unsigned CntW = $clog2(WIDTH + 2);
`ifdef SIPO_PARITY_EN
  localparam int unsigned FrameLen = WIDTH + 1;
`else
  localparam int unsigned FrameLen = WIDTH;
`endif
  localparam logic [CntW-1:0] LastCnt = CntW'(FrameLen - 1);

  logic [WIDTH-1:0] sr_q, sr_d, shifted, word;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             perr_q, perr_d, perr_word;
  logic             complete, load;

  always_comb begin
    shifted  = MSB_FIRST ? {sr_q[WIDTH-2:0], serial_in} : {serial_in, sr_q[WIDTH-1:1]};
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    complete = 1'b0;
    if (clear) begin
      cnt_d = '0;
      sr_d  = '0;
    end else if (serial_valid) begin
      if (cnt_q == LastCnt) begin
        complete = 1'b1;
        cnt_d    = '0;
        sr_d     = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
        sr_d  = shifted;
      end
    end
`ifdef SIPO_PARITY_EN
    // The final bit is the parity bit; the data bits are already complete in sr_q.
    word      = sr_q;
    perr_word = (^sr_q) ^ serial_in;
`else
    word      = shifted;
    perr_word = 1'b0;
`endif
  end

  always_comb begin
    load      = complete & (~valid_q | out_ready);
    data_d    = load ? word : data_q;
    perr_d    = load ? perr_word : perr_q;
    valid_d   = load | (valid_q & ~out_ready);
    overrun_d = complete & valid_q & ~out_ready;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sr_q      <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      perr_q    <= perr_d;
    end
  end

  assign out_data       = data_q;
  assign out_valid      = valid_q;
  assign overrun        = overrun_q;
  assign out_parity_err = perr_q;
  assign bit_count      = cnt_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Randomized and directed bench for sipo_deserializer (both bit orders) against a queue-based model.
module tb_sipo_deserializer;

  localparam int unsigned W = 8;
`ifdef SIPO_PARITY_EN
  localparam int unsigned FL = W + 1;
`else
  localparam int unsigned FL = W;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         serial_in = 1'b0, serial_valid = 1'b0, clear = 1'b0, out_ready = 1'b0;
  logic [W-1:0] data_m, data_l;
  logic         valid_m, valid_l, ovr_m, ovr_l, perr_m, perr_l;
  logic [3:0]   cnt_m, cnt_l;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit           frame[$];
  logic [W-1:0] exp_m, exp_l;
  logic         exp_valid, exp_ovr, exp_perr;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset_n(reset_n), .serial_in(serial_in), .serial_valid(serial_valid),
    .clear(clear), .out_data(data_m), .out_valid(valid_m), .out_ready(out_ready),
    .overrun(ovr_m), .out_parity_err(perr_m), .bit_count(cnt_m)
  );

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset_n(reset_n), .serial_in(serial_in), .serial_valid(serial_valid),
    .clear(clear), .out_data(data_l), .out_valid(valid_l), .out_ready(out_ready),
    .overrun(ovr_l), .out_parity_err(perr_l), .bit_count(cnt_l)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit sv, input bit si, input bit clr, input bit rdy,
                            input bit rst);
    bit           complete = 1'b0;
    logic [W-1:0] wm = '0, wl = '0;
    bit           par = 1'b0;
    if (!rst) begin
      frame.delete();
      exp_m = '0; exp_l = '0; exp_valid = 1'b0; exp_ovr = 1'b0; exp_perr = 1'b0;
      return;
    end
    if (clr) frame.delete();
    else if (sv) begin
      frame.push_back(si);
      if (frame.size() == FL) begin
        complete = 1'b1;
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = frame[i];
          wl[i]     = frame[i];
          par       = par ^ frame[i];
        end
        if (FL > W) par = par ^ frame[W];
        else        par = 1'b0;
        frame.delete();
      end
    end
    exp_ovr = complete && exp_valid && !rdy;
    if (complete && (!exp_valid || rdy)) begin
      exp_m = wm; exp_l = wl; exp_perr = par; exp_valid = 1'b1;
    end else if (exp_valid && rdy) begin
      exp_valid = 1'b0;
    end
  endtask

  task automatic step(input bit sv, input bit si, input bit clr, input bit rdy, input bit rst);
    @(negedge clk);
    serial_valid = sv; serial_in = si; clear = clr; out_ready = rdy; reset_n = rst;
    @(posedge clk);
    model_edge(sv, si, clr, rdy, rst);
    #1;
    check("data_msb", data_m, exp_m);
    check("data_lsb", data_l, exp_l);
    check("valid_msb", valid_m, exp_valid);
    check("valid_lsb", valid_l, exp_valid);
    check("overrun", {ovr_m, ovr_l}, {exp_ovr, exp_ovr});
    check("parity_err", {perr_m, perr_l}, {exp_perr, exp_perr});
    check("bit_count_msb", cnt_m, frame.size());
    check("bit_count_lsb", cnt_l, frame.size());
  endtask

  // Sends w first-bit-first from w[W-1]; rdy on all but the final bit, last_rdy on the final bit.
  task automatic send_word(input logic [W-1:0] w, input bit rdy, input bit last_rdy,
                           input bit flip_par);
    bit bits[$];
    for (int i = W - 1; i >= 0; i--) bits.push_back(w[i]);
    if (FL > W) bits.push_back((^w) ^ flip_par);
    for (int i = 0; i < bits.size(); i++)
      step(1'b1, bits[i], 1'b0, (i == bits.size() - 1) ? last_rdy : rdy, 1'b1);
  endtask

  initial begin
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_valid", valid_m, 1'b0);
    check("reset_count", cnt_m, 4'd0);

    // Basic frame, both bit orders
    send_word(8'hB2, 1'b1, 1'b1, 1'b0);
    check("tp_msb_b2", data_m, 8'hB2);
    check("tp_lsb_4d", data_l, 8'h4D);
    check("tp_valid", valid_m, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("tp_valid_drop", valid_m, 1'b0);

    // Backpressure and overrun
    send_word(8'hB2, 1'b0, 1'b0, 1'b0);
    send_word(8'hFF, 1'b0, 1'b0, 1'b0);
    check("bp_hold", data_m, 8'hB2);
    check("bp_overrun", ovr_m, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("bp_overrun_pulse", ovr_m, 1'b0);
    check("bp_valid", valid_m, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("bp_transfer", valid_m, 1'b0);

    // Simultaneous transfer and completion
    send_word(8'hB2, 1'b1, 1'b1, 1'b0);
    send_word(8'h0F, 1'b0, 1'b1, 1'b0);
    check("sim_data", data_m, 8'h0F);
    check("sim_valid", valid_m, 1'b1);
    check("sim_no_ovr", ovr_m, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Reset mid-frame
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("rst_count", cnt_m, 4'd0);
    send_word(8'hA5, 1'b1, 1'b1, 1'b0);
    check("rst_a5", data_m, 8'hA5);

    // Clear mid-frame with a held word
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send_word(8'h3C, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check("clr_count", cnt_m, 4'd0);
    check("clr_held", data_m, 8'h3C);
    check("clr_valid", valid_m, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send_word(8'hA5, 1'b1, 1'b1, 1'b0);
    check("clr_a5", data_m, 8'hA5);

`ifdef SIPO_PARITY_EN
    send_word(8'hB2, 1'b1, 1'b1, 1'b0);
    check("par_ok", perr_m, 1'b0);
    send_word(8'hB2, 1'b1, 1'b1, 1'b1);
    check("par_err", perr_m, 1'b1);
`endif

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 99) < 3,
           $urandom_range(0, 9) < 6, $urandom_range(0, 199) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
# sipo_deserializer

Parametrised serial-in/parallel-out deserializer, successor to the fixed 4-bit SIPO shift register. It assembles WIDTH-bit words from a strobed serial bit stream, with selectable bit order. Completed words move into a double-buffered output register with a valid/ready handshake, so a new word can assemble while the previous one waits. It sits between a serial link front-end and any word-oriented consumer in the design.

## Interface
- WIDTH, 8, data word width in bits; legal range ≥ 2.
- MSB_FIRST, 1, bit order:
  - 1: first received bit lands in out_data[WIDTH-1] (left shift, new bit enters LSB).
  - 0: first received bit lands in out_data[0] (right shift, new bit enters MSB).
- clk  input  1  single clock; all state changes on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- serial_in  input  1  serial data bit; sampled only when serial_valid=1.
- serial_valid  input  1  bit strobe; one bit accepted per cycle it is high.
- clear  input  1  synchronous abort of the partial frame; holding register unaffected.
- out_data  output  WIDTH  assembled word (holding register).
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts the word when out_valid & out_ready.
- overrun  output  1  one-cycle pulse: a completed word was dropped.
- out_parity_err  output  1  parity error flag for the word in out_data.
- bit_count  output  $clog2(WIDTH+2)  bits accumulated in the current partial frame.

## Operation
- Frame length is FL = WIDTH, or WIDTH+1 with SIPO_PARITY_EN.
- Shift register and bit_count advance only on serial_valid=1. bit_count counts 0..FL-1.
- Frame completion: serial_valid=1 while bit_count=FL-1. On that edge, bit_count returns to 0 and the completed data bits are offered to the holding register.
- Handshake:
  - Transfer occurs on any edge with out_valid & out_ready.
  - out_valid falls after a transfer unless a new word loads on the same edge.
  - out_data is stable while out_valid=1 and out_ready=0.
- Holding register load on completion:
  - If out_valid=0, or out_valid & out_ready: load the word and set out_valid=1. With simultaneous transfer and completion, out_valid stays 1 and carries the new word.
  - If out_valid=1 and out_ready=0: drop the new word, keep the old one, and pulse overrun high for exactly the next cycle.
- clear=1 resets bit_count and the shift register to 0. clear wins over a same-cycle serial_valid, and that bit is discarded. out_data, out_valid and out_parity_err are untouched.
- Reset (reset_n=0 at an edge) has priority over everything. It returns every output to 0: out_data=0, out_valid=0, overrun=0, out_parity_err=0, bit_count=0. Reset mid-frame discards the partial frame.

## Timing
- Latency: out_valid rises, with the word on out_data, on the edge that samples the last frame bit. It is visible the cycle after that bit is presented.
- Maximum throughput is one bit per cycle. Back-to-back frames need no idle cycles.
- No combinational path from any input to any output; all outputs are registered.
- overrun asserts on the same edge as the would-be load.

## Configuration
- SIPO_PARITY_EN defined:
  - Each frame carries one extra trailing bit, even parity over the WIDTH data bits.
  - The parity bit is not stored in out_data.
  - out_parity_err is loaded with (XOR of data bits ^ parity bit) together with out_data, and is meaningful while out_valid=1.
- SIPO_PARITY_EN undefined:
  - Frame is WIDTH bits.
  - The out_parity_err port still exists and is held 0.

## Test plan
- WIDTH=8, MSB_FIRST=1, out_ready=1, bits 1,0,1,1,0,0,1,0 on consecutive cycles -> out_data=8'hB2 with out_valid high for one cycle after the 8th bit. bit_count steps 1..7, then 0.
- Same stimulus with MSB_FIRST=0 -> out_data=8'h4D.
- Backpressure:
  - out_ready=0; send 8'hB2 then 8'hFF -> out_data stays 8'hB2, overrun pulses once after the 16th bit, out_valid stays 1.
  - Then raise out_ready -> one transfer, out_valid=0.
- Simultaneous transfer and completion: out_valid=1 with 8'hB2, out_ready=1 on the edge completing 8'h0F -> out_data=8'h0F, out_valid stays 1, no overrun.
- Mid-frame abort:
  - 5 bits then reset_n=0 for 1 cycle -> all outputs 0. The next 8 bits 0xA5 produce exactly 8'hA5.
  - Repeat with clear instead of reset -> same result, and a previously held word is unchanged.
- SIPO_PARITY_EN, 8'hB2 + parity 0 -> out_parity_err=0. With parity 1 -> out_parity_err=1. Macro undefined -> out_parity_err=0 throughout.
